// File: rtl/booth3_pkg.sv
// Shared types and helpers for the Booth-3 (radix-8) multiplier family.
package booth3_pkg;

  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

  typedef enum logic [2:0] {ZERO, X1, X2, X3, X4} sel_t;

  typedef struct packed {
    sel_t sel;
    logic neg;
  } digit_t;

  // Number of radix-8 digits for a WIDTH-bit operand plus two extension bits.
  function automatic int unsigned booth3_nd(input int unsigned width);
    return (width + 4) / 3;
  endfunction

endpackage

// File: rtl/booth3_digit_sel.sv
// Radix-8 Booth recoder: 4-bit window {b[3i+2:3i], b[3i-1]} -> multiple and sign.
module booth3_digit_sel
  import booth3_pkg::*;
(
  input  logic [3:0] win,
  output digit_t     digit_c
);

  always_comb begin
    digit_c = '{sel: ZERO, neg: 1'b0};
    case (win)
      4'b0001, 4'b0010: digit_c.sel = X1;
      4'b0011, 4'b0100: digit_c.sel = X2;
      4'b0101, 4'b0110: digit_c.sel = X3;
      4'b0111:          digit_c.sel = X4;
      4'b1000:          digit_c = '{sel: X4, neg: 1'b1};
      4'b1001, 4'b1010: digit_c = '{sel: X3, neg: 1'b1};
      4'b1011, 4'b1100: digit_c = '{sel: X2, neg: 1'b1};
      4'b1101, 4'b1110: digit_c = '{sel: X1, neg: 1'b1};
      default: ;
    endcase
  end

endmodule

// File: rtl/booth3_mac_seq.sv
// Iterative radix-8 Booth multiply / multiply-add, one digit per cycle.
// Define BOOTH3_ACC_EN to add the acc_in addend port (fused multiply-add).
module booth3_mac_seq
  import booth3_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
`ifdef BOOTH3_ACC_EN
  ,
  input  logic [2*WIDTH-1:0]   acc_in
`endif
);

  localparam int unsigned ND = booth3_nd(WIDTH);
  localparam int unsigned AW = 2 * WIDTH + 3;
  localparam int unsigned MW = 3 * ND + 1;
  localparam int unsigned CW = $clog2(ND) + 1;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sgn_q;
  logic [AW-1:0]      x_q;
  logic [AW-1:0]      x3_q;
  logic [AW-1:0]      acc_q;
  logic [MW-1:0]      m_q;
  logic [CW-1:0]      cnt_q;
`ifdef BOOTH3_ACC_EN
  logic [2*WIDTH-1:0] acc_in_q;
`endif

  digit_t             dig_c;
  logic [AW-1:0]      xa_c;
  logic [MW-1:0]      mb_c;
  logic [AW-1:0]      pp_c;
  logic [AW-1:0]      sum_c;
  logic [AW-1:0]      acc_init_c;

  booth3_digit_sel u_digit_sel (
    .win     (m_q[3:0]),
    .digit_c (dig_c)
  );

  // Operand extension, partial-product select and accumulate.
  always_comb begin
    xa_c = {{(AW - WIDTH){sgn_q & a_q[WIDTH-1]}}, a_q};
    mb_c = {{(MW - 1 - WIDTH){sgn_q & b_q[WIDTH-1]}}, b_q, 1'b0};
    pp_c = '0;
    case (dig_c.sel)
      X1:      pp_c = x_q;
      X2:      pp_c = x_q << 1;
      X3:      pp_c = x3_q;
      X4:      pp_c = x_q << 2;
      default: pp_c = '0;
    endcase
    sum_c = acc_q + (dig_c.neg ? ~pp_c : pp_c) + AW'(dig_c.neg);
`ifdef BOOTH3_ACC_EN
    acc_init_c = AW'(acc_in_q);
`else
    acc_init_c = '0;
`endif
  end

  // Control FSM and datapath registers; multiplicands shift left 3 per digit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      x_q       <= '0;
      x3_q      <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
`ifdef BOOTH3_ACC_EN
      acc_in_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            sgn_q    <= sgn;
`ifdef BOOTH3_ACC_EN
            acc_in_q <= acc_in;
`endif
            in_ready <= 1'b0;
            state    <= PRE;
          end
        end
        PRE: begin
          x_q   <= xa_c;
          x3_q  <= (xa_c << 1) + xa_c;
          m_q   <= mb_c;
          acc_q <= acc_init_c;
          cnt_q <= '0;
          state <= ITER;
        end
        ITER: begin
          acc_q <= sum_c;
          m_q   <= m_q >> 3;
          x_q   <= x_q << 3;
          x3_q  <= x3_q << 3;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(ND - 1)) begin
            out_valid <= 1'b1;
            result    <= sum_c[2*WIDTH-1:0];
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth3_mac_seq.sv
// Self-checking bench for booth3_mac_seq (WIDTH=16 and WIDTH=8 instances).
module tb_booth3_mac_seq;

`ifdef BOOTH3_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif
  localparam int N16 = 1000;
  localparam int N8  = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sgn, out_valid, out_ready;
  logic [15:0] a, b;
  logic [31:0] acc_in, result;

  logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] acc_in8, result8;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] q[$];
  bit busy = 1'b0;
  bit acc_evt = 1'b0;
  bit go = 1'b0;
  bit go8 = 1'b0;
  bit done8 = 1'b0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  booth3_mac_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
`ifdef BOOTH3_ACC_EN
    , .acc_in(acc_in)
`endif
  );

  booth3_mac_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sgn(sgn8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8)
`ifdef BOOTH3_ACC_EN
    , .acc_in(acc_in8)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Golden model: plain integer product in the selected signedness, plus addend.
  function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic s, input logic [31:0] c);
    longint px, py;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    return 32'(px * py) + (ACC_ON ? c : 32'd0);
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y,
                                         input logic s, input logic [15:0] c);
    longint px, py;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    return 16'(px * py) + (ACC_ON ? c : 16'd0);
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  always @(negedge clk) if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);

  // Monitor / compare for the 16-bit unit, sampled just before each rising edge.
  initial begin
    int lat;
    bit seen;
    lat = 0;
    seen = 1'b0;
    wait (go);
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        q.delete();
        busy = 1'b0;
      end else begin
        if (busy) begin
          check("in_ready_busy", 64'(in_ready), 64'd0);
          lat++;
        end else begin
          check("in_ready_idle", 64'(in_ready), 64'd1);
        end
        if (out_valid) begin
          if (!busy || q.size() == 0) begin
            check("spurious_out_valid", 64'(out_valid), 64'd0);
          end else begin
            check("result_vs_model", 64'(result), 64'(q[0]));
            if (!seen) begin
              check("latency16", 64'(lat), 64'd7);
              seen = 1'b1;
            end
            if (out_ready) begin
              void'(q.pop_front());
              busy = 1'b0;
            end
          end
        end else if (busy && lat > 7) begin
          check("late_out_valid", 64'(out_valid), 64'd1);
        end
        if (in_valid && in_ready) begin
          q.push_back(model16(a, b, sgn, acc_in));
          busy = 1'b1;
          lat = -1;
          seen = 1'b0;
          acc_evt = 1'b1;
        end
      end
    end
  end

  task automatic run_dir(input string nm, input logic [15:0] xa, input logic [15:0] xb,
                         input logic xs, input logic [31:0] xc, input logic [31:0] exp,
                         input int stall);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    a = xa; b = xb; sgn = xs; acc_in = xc;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_latency"}, 64'(cyc - 1), 64'd7);
    check({nm, "_result"}, 64'(result), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      in_valid = i[0];
      @(negedge clk);
      check({nm, "_hold_result"}, 64'(result), 64'(exp));
      check({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({nm, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({nm, "_consumed_valid"}, 64'(out_valid), 64'd0);
    check({nm, "_consumed_in_ready"}, 64'(in_ready), 64'd1);
    check({nm, "_idle_result"}, 64'(result), 64'(exp));
    out_ready = 1'b0;
  endtask

  // 8-bit unit: serial randomized transactions with random result stalls.
  initial begin
    int guard, c;
    bit got;
    logic [15:0] exp8;
    wait (go8);
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < N8; k++) begin
        guard = 0;
        while (!in_ready8 && guard < 20) begin
          @(negedge clk);
          guard++;
        end
        check("in_ready8_wait", 64'(in_ready8), 64'd1);
        a8 = pick8(); b8 = pick8(); sgn8 = s[0]; acc_in8 = 16'($urandom);
        exp8 = model8(a8, b8, sgn8, acc_in8);
        in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        got = 1'b0;
        for (c = 0; c < 40 && !got; c++) begin
          @(negedge clk);
          out_ready8 = ($urandom_range(0, 2) != 0);
          if (out_valid8) begin
            check("result8_vs_model", 64'(result8), 64'(exp8));
            if (out_ready8) got = 1'b1;
          end
          // c+1 = edges since the accepting edge when out_valid8 is first seen
          if (out_valid8 && c < 5) check("latency8", 64'(c + 1), 64'd5);
        end
        check("result8_handshake", 64'(got), 64'd1);
      end
    end
    done8 = 1'b1;
  end

  initial begin
    int done_n, guard;
    rst = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; acc_in = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sgn8 = 1'b0; acc_in8 = '0; out_ready8 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_in_ready8", 64'(in_ready8), 64'd1);
    check("reset_out_valid8", 64'(out_valid8), 64'd0);
    rst = 1'b1;
    go = 1'b1;
    @(negedge clk);

    run_dir("s_min_sq", 16'h8000, 16'h8000, 1'b1, 32'd0, 32'h40000000, 0);
    run_dir("u_max_sq", 16'hFFFF, 16'hFFFF, 1'b0, 32'd0, 32'hFFFE0001, 0);
    run_dir("s_neg1_sq", 16'hFFFF, 16'hFFFF, 1'b1, 32'd0, 32'h00000001, 2);
    run_dir("s_stall", 16'hFFFF, 16'h0002, 1'b1, 32'd0, 32'hFFFFFFFE, 5);

    // Reset in the middle of an iteration, with in_valid held high.
    a = 16'h1234; b = 16'h5678; sgn = 1'b0; acc_in = 32'd0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    run_dir("after_rst", 16'd3, 16'd5, 1'b0, 32'd0, 32'h0000000F, 1);
    run_dir("mac", 16'd3, 16'd4, 1'b0, 32'hFFFFFFFF, ACC_ON ? 32'h0000000B : 32'h0000000C, 0);

    // Randomized traffic on both instances.
    acc_evt = 1'b0;
    rand_ready = 1'b1;
    go8 = 1'b1;
    for (int s = 0; s < 2; s++) begin
      done_n = 0;
      guard = 0;
      while (done_n < N16 && guard < N16 * 40) begin
        @(negedge clk);
        guard++;
        if (acc_evt) begin
          acc_evt = 1'b0;
          in_valid = 1'b0;
          done_n++;
        end
        if (done_n < N16 && !in_valid && $urandom_range(0, 1) == 1) begin
          a = pick16(); b = pick16(); sgn = s[0]; acc_in = $urandom;
          in_valid = 1'b1;
        end
      end
      check("rand16_progress", 64'(done_n), 64'(N16));
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    guard = 0;
    while ((busy || q.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain16", 64'(q.size()), 64'd0);
    guard = 0;
    while (!done8 && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    check("done8", 64'(done8), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
